// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, ALU codes,
// PC/register-destination selects and the per-opcode ALU operation table.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_RS  = 2'b10;
  localparam logic [1:0] PCSRC_JMP = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    case (op)
      OP_SUB:         alu_op_of = ALU_SUB;
      OP_OR, OP_ORI:  alu_op_of = ALU_OR;
      OP_AND:         alu_op_of = ALU_AND;
      OP_SLL:         alu_op_of = ALU_SLL;
      OP_SLT:         alu_op_of = ALU_SLT;
      OP_SLTIU:       alu_op_of = ALU_SLTU;
      default:        alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_op_decode.sv
// Opcode classifier: sorts the latched opcode into instruction classes.
// An opcode outside every class leaves all flags low and runs as a no-op.
module op_decode
  import ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic [5:0] op_code,
  output logic       is_alu,
  output logic       is_imm,
  output logic       is_branch,
  output logic       is_ls,
  output logic       is_jump,
  output logic       is_halt
);

  // Halt takes priority so a HALT_OP that aliases another opcode still stops.
  always_comb begin
    is_alu    = 1'b0;
    is_imm    = 1'b0;
    is_branch = 1'b0;
    is_ls     = 1'b0;
    is_jump   = 1'b0;
    is_halt   = (op_code == HALT_OP);
    if (!is_halt) begin
      case (op_code)
        OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT: is_alu    = 1'b1;
        OP_ADDI, OP_ORI, OP_SLTIU:                     is_imm    = 1'b1;
        OP_BEQ, OP_BNE, OP_BLTZ:                       is_branch = 1'b1;
        OP_SW, OP_LW:                                  is_ls     = 1'b1;
        OP_J, OP_JR, OP_JAL:                           is_jump   = 1'b1;
        default:                                       is_alu    = 1'b0;
      endcase
    end else begin
      is_alu = 1'b0;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: sequencing FSM with a sticky halt flag and
// combinational control outputs decoded from state, opcode and ALU flags.
module control_unit
  import ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [5:0] Op_code,
  input  logic       Zero,
  input  logic       Sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ExtSel,
  output logic       RegWre,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic [1:0] RegDst,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic [2:0] State,
  output logic       Halted
);

  state_t state_r;
  logic   halted_r;
  logic   alu_s, imm_s, branch_s, ls_s, jump_s, halt_s;
  logic   taken_s;

  op_decode #(.HALT_OP(HALT_OP)) u_op_decode (
    .op_code   (Op_code),
    .is_alu    (alu_s),
    .is_imm    (imm_s),
    .is_branch (branch_s),
    .is_ls     (ls_s),
    .is_jump   (jump_s),
    .is_halt   (halt_s)
  );

  assign taken_s = ((Op_code == OP_BEQ)  &&  Zero) ||
                   ((Op_code == OP_BNE)  && !Zero) ||
                   ((Op_code == OP_BLTZ) &&  Sign);

  // Instruction sequencing; once halted the machine parks in IF until reset.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r  <= S_IF;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        S_IF: begin
          if (halted_r) state_r <= S_IF;
          else          state_r <= S_ID;
        end
        S_ID: begin
          if (halt_s) begin
            halted_r <= 1'b1;
            state_r  <= S_IF;
          end
          else if (branch_s) state_r <= S_EXE_BR;
          else if (ls_s)     state_r <= S_EXE_LS;
          else if (jump_s)   state_r <= S_IF;
          else               state_r <= S_EXE_AL;
        end
        S_EXE_AL: state_r <= S_WB_AL;
        S_WB_AL:  state_r <= S_IF;
        S_EXE_BR: state_r <= S_IF;
        S_EXE_LS: state_r <= S_MEM;
        S_MEM: begin
          if (Op_code == OP_LW) state_r <= S_WB_LD;
          else                  state_r <= S_IF;
        end
        S_WB_LD:  state_r <= S_IF;
        default:  state_r <= S_IF;
      endcase
    end
  end

  // Strobes are qualified by RST_n so they drop the moment reset asserts.
  always_comb begin
    InsMemRW  = 1'b1;
    ExtSel    = (Op_code != OP_ORI);
    ALUSrcA   = (Op_code == OP_SLL);
    ALUSrcB   = imm_s | ls_s;
    DBDataSrc = (Op_code == OP_LW);
    WrRegDSrc = (Op_code != OP_JAL);

    if (Op_code == OP_JAL)                 RegDst = REGDST_RA;
    else if (imm_s || Op_code == OP_LW)    RegDst = REGDST_RT;
    else                                   RegDst = REGDST_RD;

    if (branch_s)  ALUOp = ALU_SUB;
    else if (ls_s) ALUOp = ALU_ADD;
    else           ALUOp = alu_op_of(Op_code);

    if (jump_s && Op_code == OP_JR)              PCSrc = PCSRC_RS;
    else if (jump_s)                             PCSrc = PCSRC_JMP;
    else if (state_r == S_EXE_BR && taken_s)     PCSrc = PCSRC_BR;
    else                                         PCSrc = PCSRC_SEQ;

    IRWre  = RST_n && !halted_r && (state_r == S_IF);
    PCWre  = RST_n && !halted_r &&
             ((state_r == S_ID && jump_s) || (state_r == S_EXE_BR) ||
              (state_r == S_WB_AL) || (state_r == S_WB_LD) ||
              (state_r == S_MEM && Op_code == OP_SW));
    RegWre = RST_n &&
             ((state_r == S_WB_AL && (alu_s || imm_s)) || (state_r == S_WB_LD) ||
              (state_r == S_ID && jump_s && Op_code == OP_JAL));
    mRD    = RST_n && (state_r == S_MEM) && (Op_code == OP_LW);
    mWR    = RST_n && (state_r == S_MEM) && (Op_code == OP_SW);
    State  = state_r;
    Halted = halted_r;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: an instruction-level model expands each
// opcode into its per-cycle expected outputs, checked every falling edge.
module tb_control_unit;

  localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_ADDI = 6'b000010;
  localparam logic [5:0] T_OR = 6'b010000, T_AND = 6'b010001, T_ORI = 6'b010010;
  localparam logic [5:0] T_SLL = 6'b011000, T_SLT = 6'b100110, T_SLTIU = 6'b100111;
  localparam logic [5:0] T_SW = 6'b110000, T_LW = 6'b110001;
  localparam logic [5:0] T_BEQ = 6'b110100, T_BNE = 6'b110101, T_BLTZ = 6'b110110;
  localparam logic [5:0] T_J = 6'b111000, T_JR = 6'b111001, T_JAL = 6'b111010;
  localparam logic [5:0] T_HALT = 6'b111111, T_UNK = 6'b001111;

  logic CLK, RST_n, Zero, Sign;
  logic [5:0] Op_code;
  logic PCWre, IRWre, InsMemRW, ExtSel, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp, State;
  logic mRD, mWR, Halted;

  typedef struct packed {
    logic [2:0] st;
    logic ir, pc, rw, rd, wr, hl;
    logic [1:0] pcs, dst;
    logic [2:0] aop;
    logic dbs, wrs, asa, asb, ext;
  } rec_t;

  rec_t exp_q[$];
  rec_t cur_e;
  rec_t pin_e;
  int total = 0;
  int bad = 0;
  bit halted_m = 1'b0;

  control_unit dut (
    .CLK(CLK), .RST_n(RST_n), .Op_code(Op_code), .Zero(Zero), .Sign(Sign),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
    .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
    .WrRegDSrc(WrRegDSrc), .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .mRD(mRD), .mWR(mWR), .State(State), .Halted(Halted)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int lat(input logic [5:0] op);
    if (op inside {T_BEQ, T_BNE, T_BLTZ}) return 3;
    if (op inside {T_J, T_JR, T_JAL, T_HALT}) return 2;
    if (op == T_LW) return 5;
    return 4;
  endfunction

  // Expected outputs for cycle k of instruction op (h: machine already halted).
  function automatic rec_t model(input logic [5:0] op, input logic z, input logic s,
                                 input int k, input bit h);
    rec_t r;
    bit is_r, is_i, is_br, is_ls, is_h, taken;
    int n;
    is_r  = op inside {T_ADD, T_SUB, T_OR, T_AND, T_SLL, T_SLT};
    is_i  = op inside {T_ADDI, T_ORI, T_SLTIU};
    is_br = op inside {T_BEQ, T_BNE, T_BLTZ};
    is_ls = op inside {T_SW, T_LW};
    is_h  = (op == T_HALT);
    n     = lat(op);
    taken = (op == T_BEQ && z) || (op == T_BNE && !z) || (op == T_BLTZ && s);
    if (k == 0)      r.st = 3'd0;
    else if (k == 1) r.st = 3'd1;
    else if (is_br)  r.st = 3'd5;
    else if (is_ls)  r.st = 3'(k);
    else             r.st = (k == 2) ? 3'd6 : 3'd7;
    r.ir = (k == 0);
    r.pc = !is_h && (k == n - 1);
    r.rw = ((k == n - 1) && (is_r || is_i || op == T_LW)) || (op == T_JAL && k == 1);
    r.rd = (op == T_LW) && (k == 3);
    r.wr = (op == T_SW) && (k == 3);
    r.hl = 1'b0;
    if (op == T_JR)                     r.pcs = 2'b10;
    else if (op == T_J || op == T_JAL)  r.pcs = 2'b11;
    else if (is_br && k == 2 && taken)  r.pcs = 2'b01;
    else                                r.pcs = 2'b00;
    if (op == T_JAL)                    r.dst = 2'b00;
    else if (is_i || op == T_LW)        r.dst = 2'b01;
    else                                r.dst = 2'b10;
    case (op)
      T_BEQ, T_BNE, T_BLTZ, T_SUB: r.aop = 3'b001;
      T_OR, T_ORI:                 r.aop = 3'b011;
      T_AND:                       r.aop = 3'b100;
      T_SLL:                       r.aop = 3'b010;
      T_SLT:                       r.aop = 3'b110;
      T_SLTIU:                     r.aop = 3'b101;
      default:                     r.aop = 3'b000;
    endcase
    r.dbs = (op == T_LW);
    r.wrs = (op != T_JAL);
    r.asa = (op == T_SLL);
    r.asb = is_i || is_ls;
    r.ext = (op != T_ORI);
    if (h) begin
      r.st = 3'd0; r.ir = 1'b0; r.pc = 1'b0; r.rw = 1'b0;
      r.rd = 1'b0; r.wr = 1'b0; r.hl = 1'b1; r.pcs = 2'b00;
    end
    return r;
  endfunction

  // Single compare process: one expected record per falling edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      chk("State", {5'd0, State}, {5'd0, cur_e.st});
      chk("IRWre", {7'd0, IRWre}, {7'd0, cur_e.ir});
      chk("PCWre", {7'd0, PCWre}, {7'd0, cur_e.pc});
      chk("RegWre", {7'd0, RegWre}, {7'd0, cur_e.rw});
      chk("mRD", {7'd0, mRD}, {7'd0, cur_e.rd});
      chk("mWR", {7'd0, mWR}, {7'd0, cur_e.wr});
      chk("Halted", {7'd0, Halted}, {7'd0, cur_e.hl});
      chk("PCSrc", {6'd0, PCSrc}, {6'd0, cur_e.pcs});
      chk("RegDst", {6'd0, RegDst}, {6'd0, cur_e.dst});
      chk("ALUOp", {5'd0, ALUOp}, {5'd0, cur_e.aop});
      chk("mux_sel", {3'd0, DBDataSrc, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel},
          {3'd0, cur_e.dbs, cur_e.wrs, cur_e.asa, cur_e.asb, cur_e.ext});
      chk("InsMemRW", {7'd0, InsMemRW}, 8'd1);
    end
  end

  task automatic run(input logic [5:0] op, input logic z, input logic s);
    int n;
    n = lat(op);
    Op_code = op; Zero = z; Sign = s;
    for (int k = 0; k < n; k++) exp_q.push_back(model(op, z, s, k, halted_m));
    repeat (n) @(posedge CLK);
    #1;
    if (op == T_HALT) halted_m = 1'b1;
  endtask

  task automatic frozen(input int ncyc);
    for (int k = 0; k < ncyc; k++) exp_q.push_back(model(Op_code, Zero, Sign, 0, 1'b1));
    repeat (ncyc) @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_state"}, {5'd0, State}, 8'd0);
    chk({nm, "_strobes"}, {3'd0, IRWre, PCWre, RegWre, mRD, mWR}, 8'd0);
    chk({nm, "_halted"}, {7'd0, Halted}, 8'd0);
    chk({nm, "_insmem"}, {7'd0, InsMemRW}, 8'd1);
  endtask

  task automatic pulse_reset();
    RST_n = 1'b0;
    #1;
    chk_reset("rst_pulse");
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    halted_m = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_n = 1'b0; Op_code = T_ADD; Zero = 1'b0; Sign = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset("reset");
    RST_n = 1'b1;

    // Hand-computed pins on the model itself.
    pin_e = model(T_ADD, 1'b0, 1'b0, 3, 1'b0);
    chk("pin_add_wb", {pin_e.st, pin_e.rw, pin_e.pc, 1'b0, pin_e.dst}, {3'b111, 1'b1, 1'b1, 1'b0, 2'b10});
    pin_e = model(T_LW, 1'b0, 1'b0, 4, 1'b0);
    chk("pin_lw_wb", {pin_e.st, pin_e.dbs, pin_e.rw, 1'b0, pin_e.dst}, {3'b100, 1'b1, 1'b1, 1'b0, 2'b01});
    pin_e = model(T_BEQ, 1'b1, 1'b0, 2, 1'b0);
    chk("pin_beq_taken", {pin_e.st, pin_e.pc, 2'b00, pin_e.pcs}, {3'b101, 1'b1, 2'b00, 2'b01});
    pin_e = model(T_JAL, 1'b0, 1'b0, 1, 1'b0);
    chk("pin_jal_id", {pin_e.rw, pin_e.dst, pin_e.wrs, pin_e.pcs, pin_e.pc},
        {1'b1, 2'b00, 1'b0, 2'b11, 1'b1});
    chk("pin_lat", 8'(lat(T_ADD) * 16 + lat(T_LW)), 8'h45);

    run(T_ADD, 1'b0, 1'b0);
    run(T_LW, 1'b0, 1'b0);
    run(T_BEQ, 1'b1, 1'b0);
    run(T_BEQ, 1'b0, 1'b0);
    run(T_BNE, 1'b0, 1'b0);
    run(T_BNE, 1'b1, 1'b0);
    run(T_BLTZ, 1'b0, 1'b1);
    run(T_BLTZ, 1'b1, 1'b0);
    run(T_JAL, 1'b0, 1'b0);
    run(T_J, 1'b0, 1'b0);
    run(T_JR, 1'b0, 1'b0);
    run(T_SW, 1'b0, 1'b0);
    run(T_SUB, 1'b0, 1'b0);
    run(T_ADDI, 1'b0, 1'b0);
    run(T_ORI, 1'b0, 1'b0);
    run(T_SLL, 1'b0, 1'b0);
    run(T_SLT, 1'b0, 1'b0);
    run(T_SLTIU, 1'b0, 1'b0);
    run(T_AND, 1'b0, 1'b0);
    run(T_OR, 1'b0, 1'b0);
    run(T_UNK, 1'b0, 1'b0);
    run(T_HALT, 1'b0, 1'b0);
    frozen(20);
    pulse_reset();
    run(T_ADD, 1'b0, 1'b0);

    // Reset asserted during MEM of sw must drop mWR with no clock edge.
    Op_code = T_SW; Zero = 1'b0; Sign = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back(model(T_SW, 1'b0, 1'b0, k, 1'b0));
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("sw_mem_mWR", {7'd0, mWR}, 8'd1);
    RST_n = 1'b0;
    #1;
    chk("async_mWR", {7'd0, mWR}, 8'd0);
    chk("async_state", {5'd0, State}, 8'd0);
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    run(T_LW, 1'b0, 1'b0);
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
